// File: rtl/matrix_scan_driver.sv
// Double-buffered LED-matrix scan driver: serialises each row into a 74HC595-style register, latches it, then lights the row.
// Define MATRIX_SCAN_BRIGHTNESS_EN to add a 4-bit brightness input that trims the lit part of each HOLD.
module matrix_scan_driver #(
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int CLK_DIV  = 4,
  parameter int ROW_HOLD = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ROWS*COLS-1:0]     frame,
  input  logic                     frame_valid,
  input  logic                     blank,
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  input  logic [3:0]               brightness,
`endif
  output logic [ROWS-1:0]          rows_out,
  output logic                     shcp,
  output logic                     stcp,
  output logic                     mr,
  output logic                     oe,
  output logic                     ds,
  output logic [$clog2(ROWS)-1:0]  row_idx,
  output logic                     frame_start
);

  localparam int RW      = $clog2(ROWS);
  localparam int CLW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_MAX = (ROW_HOLD > 2 * CLK_DIV) ? ROW_HOLD : 2 * CLK_DIV;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]   DIV_C    = CW'(CLK_DIV);
  localparam logic [CW-1:0]   DIV_M1   = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   DIV2_M1  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0]   HOLD_M1  = CW'(ROW_HOLD - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);
  localparam logic [CLW-1:0]  COL_LAST = CLW'(COLS - 1);
  localparam logic [ROWS-1:0] ROW_ONE  = ROWS'(1);

  typedef enum logic [1:0] {S_CLEAR, S_SHIFT, S_LATCH, S_HOLD} state_t;

  state_t               state_reg;
  logic [CW-1:0]        cnt_reg;
  logic [CLW-1:0]       col_reg;
  logic [CW-1:0]        duty_reg;
  logic [ROWS*COLS-1:0] shadow_reg;
  logic [ROWS*COLS-1:0] active_reg;

  logic [ROWS*COLS-1:0] reload_frame;
  logic [COLS-1:0]      active_row [ROWS];
  logic [COLS-1:0]      reload_row [ROWS];
  logic                 wrap;
  logic [RW-1:0]        next_row;
  logic [COLS-1:0]      next_bits;
  logic [COLS-1:0]      cur_bits;
  logic [ROWS-1:0]      row_onehot;
  logic [CW-1:0]        duty_next;

  // A strobe landing on the reload edge bypasses the shadow so it is shown at once.
  assign reload_frame = frame_valid ? frame : shadow_reg;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    assign active_row[gi] = active_reg[gi*COLS +: COLS];
    assign reload_row[gi] = reload_frame[gi*COLS +: COLS];
  end

  always_comb begin
    wrap       = (state_reg == S_CLEAR) || (row_idx == ROW_LAST);
    next_row   = wrap ? '0 : row_idx + 1'b1;
    next_bits  = wrap ? reload_row[next_row] : active_row[next_row];
    cur_bits   = active_row[row_idx];
    row_onehot = ROW_ONE << row_idx;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    duty_next  = CW'(((32'(brightness) + 32'd1) * ROW_HOLD) / 16);
`else
    duty_next  = CW'(ROW_HOLD);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_CLEAR;
      cnt_reg     <= '0;
      col_reg     <= '0;
      duty_reg    <= '0;
      shadow_reg  <= '0;
      active_reg  <= '0;
      rows_out    <= '0;
      shcp        <= 1'b0;
      stcp        <= 1'b0;
      mr          <= 1'b0;
      oe          <= 1'b1;
      ds          <= 1'b0;
      row_idx     <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (frame_valid) shadow_reg <= frame;

      case (state_reg)
        S_CLEAR: begin
          if (cnt_reg == DIV_C) begin
            mr          <= 1'b1;
            row_idx     <= '0;
            active_reg  <= reload_frame;
            frame_start <= 1'b1;
            state_reg   <= S_SHIFT;
            cnt_reg     <= '0;
            col_reg     <= COL_LAST;
            ds          <= next_bits[COLS-1];
            shcp        <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        // Each bit: CLK_DIV cycles with shcp low, then CLK_DIV high; ds only moves on the falling side.
        S_SHIFT: begin
          if (cnt_reg == DIV2_M1) begin
            cnt_reg <= '0;
            shcp    <= 1'b0;
            if (col_reg == '0) begin
              state_reg <= S_LATCH;
              stcp      <= 1'b1;
            end else begin
              col_reg <= col_reg - 1'b1;
              ds      <= cur_bits[col_reg - 1'b1];
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == DIV_M1) shcp <= 1'b1;
          end
        end

        S_LATCH: begin
          if (cnt_reg == DIV_M1) begin
            state_reg <= S_HOLD;
            cnt_reg   <= '0;
            stcp      <= 1'b0;
            duty_reg  <= duty_next;
            if (!blank && (duty_next != '0)) begin
              rows_out <= row_onehot;
              oe       <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        S_HOLD: begin
          if (cnt_reg == HOLD_M1) begin
            rows_out  <= '0;
            oe        <= 1'b1;
            row_idx   <= next_row;
            state_reg <= S_SHIFT;
            cnt_reg   <= '0;
            col_reg   <= COL_LAST;
            ds        <= next_bits[COLS-1];
            if (wrap) begin
              active_reg  <= reload_frame;
              frame_start <= 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
            // Outputs describe the next HOLD cycle, hence cnt+1 against the duty length.
            if (!blank && ((cnt_reg + 1'b1) < duty_reg)) begin
              rows_out <= row_onehot;
              oe       <= 1'b0;
            end else begin
              rows_out <= '0;
              oe       <= 1'b1;
            end
          end
        end

        default: state_reg <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver at ROWS=8, COLS=8, CLK_DIV=2, ROW_HOLD=16 (row period 50 cycles).
module tb_matrix_scan_driver;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CLK_DIV = 2;
  localparam int ROW_HOLD = 16;
  localparam int P = 50;
  localparam int HOLD_START = 34;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] frame = '0;
  logic        frame_valid = 1'b0;
  logic        blank = 1'b0;
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
  logic [3:0]  brightness = 4'd15;
`endif
  logic [7:0]  rows_out;
  logic        shcp, stcp, mr, oe, ds, frame_start;
  logic [2:0]  row_idx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fs = -1;
  int fs_period = 0;
  int tot_sh = 0;
  int tot_st = 0;
  logic prev_shcp = 1'b0;
  logic prev_stcp = 1'b0;
  logic prev_ds = 1'b0;

  typedef struct {
    logic [7:0] bits;
    logic       blk;
    logic [7:0] exp_word;
    logic [7:0] exp_oh;
    int         exp_lit;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] yw [8];
  logic [63:0] f0;

  matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .CLK_DIV(CLK_DIV), .ROW_HOLD(ROW_HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .frame(frame),
    .frame_valid(frame_valid),
    .blank(blank),
`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    .brightness(brightness),
`endif
    .rows_out(rows_out),
    .shcp(shcp),
    .stcp(stcp),
    .mr(mr),
    .oe(oe),
    .ds(ds),
    .row_idx(row_idx),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " rows_out"}, rows_out, 0);
    check({tag, " shcp"}, shcp, 0);
    check({tag, " stcp"}, stcp, 0);
    check({tag, " mr"}, mr, 0);
    check({tag, " oe"}, oe, 1);
    check({tag, " ds"}, ds, 0);
    check({tag, " row_idx"}, row_idx, 0);
    check({tag, " frame_start"}, frame_start, 0);
  endtask

  // Release reset and walk through CLEAR; returns on the first SHIFT cycle of row 0.
  task automatic bring_up(input logic load, input logic [63:0] f);
    frame = f;
    frame_valid = load;
    reset = 1'b0;
    step();
    frame_valid = 1'b0;
    check("clear c1 mr", mr, 0);
    check("clear c1 frame_start", frame_start, 0);
    check("clear c1 oe", oe, 1);
    step();
    check("clear c2 mr", mr, 0);
    check("clear c2 frame_start", frame_start, 0);
    step();
    check("clear c3 mr", mr, 1);
    check("clear c3 frame_start", frame_start, 1);
    check("clear c3 shcp", shcp, 0);
    prev_shcp = shcp;
    prev_stcp = stcp;
    prev_ds = ds;
    $display("bring_up load=%0d done at cycle %0d", load, cyc);
  endtask

  // Observe one full row period starting at its first SHIFT cycle.
  task automatic run_row(input int f, input int r, input logic [7:0] exp_word, input logic blk,
                         input logic [7:0] exp_oh, input int exp_lit, input logic exp_fs,
                         input int strobe_k, input logic [63:0] strobe_frame);
    logic [7:0] word = '0;
    int nsh = 0, nst = 0, sthigh = 0, lit = 0, bad = 0, unstable = 0, idx_bad = 0, fs_bad = 0;
    blank = blk;
    for (int k = 0; k < P; k++) begin
      if (shcp && !prev_shcp) begin
        nsh++;
        word = {word[6:0], ds};
        if (ds !== prev_ds) unstable++;
      end
      if (stcp && !prev_stcp) nst++;
      if (stcp) sthigh++;
      if (k < HOLD_START) begin
        if (oe !== 1'b1 || rows_out !== 8'h00) bad++;
      end else begin
        if (oe === 1'b0 && rows_out === exp_oh) lit++;
        else if (!(oe === 1'b1 && rows_out === 8'h00)) bad++;
      end
      if (row_idx !== 3'(r)) idx_bad++;
      if (frame_start !== (exp_fs && k == 0)) fs_bad++;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) fs_period = cyc - last_fs;
        last_fs = cyc;
      end
      prev_shcp = shcp;
      prev_stcp = stcp;
      prev_ds = ds;
      if (k == strobe_k) begin
        frame = strobe_frame;
        frame_valid = 1'b1;
      end
      step();
      frame_valid = 1'b0;
    end
    tot_sh += nsh;
    tot_st += nst;
    check($sformatf("f%0d r%0d ds_word", f, r), word, exp_word);
    check($sformatf("f%0d r%0d shcp_rises", f, r), nsh, 8);
    check($sformatf("f%0d r%0d stcp_rises", f, r), nst, 1);
    check($sformatf("f%0d r%0d stcp_width", f, r), sthigh, CLK_DIV);
    check($sformatf("f%0d r%0d lit_cycles", f, r), lit, exp_lit);
    check($sformatf("f%0d r%0d drive_violations", f, r), bad, 0);
    check($sformatf("f%0d r%0d ds_unstable", f, r), unstable, 0);
    check($sformatf("f%0d r%0d row_idx_bad", f, r), idx_bad, 0);
    check($sformatf("f%0d r%0d frame_start_bad", f, r), fs_bad, 0);
    $display("frame %0d row %0d word=%02h shcp=%0d stcp=%0d lit=%0d", f, r, word, nsh, nst, lit);
  endtask

  initial begin
    tbl[0] = '{bits: 8'hA3, blk: 1'b0, exp_word: 8'hA3, exp_oh: 8'h01, exp_lit: 16};
    tbl[1] = '{bits: 8'h01, blk: 1'b0, exp_word: 8'h01, exp_oh: 8'h02, exp_lit: 16};
    tbl[2] = '{bits: 8'h80, blk: 1'b0, exp_word: 8'h80, exp_oh: 8'h04, exp_lit: 16};
    tbl[3] = '{bits: 8'hFF, blk: 1'b0, exp_word: 8'hFF, exp_oh: 8'h08, exp_lit: 16};
    tbl[4] = '{bits: 8'h3C, blk: 1'b1, exp_word: 8'h3C, exp_oh: 8'h10, exp_lit: 0};
    tbl[5] = '{bits: 8'h5A, blk: 1'b0, exp_word: 8'h5A, exp_oh: 8'h20, exp_lit: 16};
    tbl[6] = '{bits: 8'hC3, blk: 1'b0, exp_word: 8'hC3, exp_oh: 8'h40, exp_lit: 16};
    tbl[7] = '{bits: 8'h7E, blk: 1'b0, exp_word: 8'h7E, exp_oh: 8'h80, exp_lit: 16};
    yw = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    f0 = '0;
    for (int r = 0; r < 8; r++) f0[r*8 +: 8] = tbl[r].bits;

    repeat (2) @(negedge clk);
    check_reset_values("power-on");
    bring_up(1'b1, f0);

    // Frame 0: table data, row 4 blanked.
    for (int r = 0; r < 8; r++)
      run_row(0, r, tbl[r].exp_word, tbl[r].blk, tbl[r].exp_oh, tbl[r].exp_lit, r == 0, -1, '0);

    // Frame 1: two strobes mid-frame must not disturb the active buffer.
    for (int r = 0; r < 8; r++) begin
      if (r == 3)
        run_row(1, r, tbl[r].exp_word, tbl[r].blk, tbl[r].exp_oh, tbl[r].exp_lit, 1'b0, 10, 64'h5555_5555_5555_5555);
      else if (r == 6)
        run_row(1, r, tbl[r].exp_word, tbl[r].blk, tbl[r].exp_oh, tbl[r].exp_lit, 1'b0, 20, 64'hFFFF_FFFF_FFFF_FFFF);
      else
        run_row(1, r, tbl[r].exp_word, tbl[r].blk, tbl[r].exp_oh, tbl[r].exp_lit, r == 0, -1, '0);
    end
    check("frame period f1", fs_period, 400);

    // Frame 2: last strobe (all ones) wins; strobe on the wrap edge of row 7.
    for (int r = 0; r < 8; r++)
      run_row(2, r, 8'hFF, 1'b0, tbl[r].exp_oh, 16, r == 0, (r == 7) ? 49 : -1, 64'hF0DE_BC9A_7856_3412);
    check("frame period f2", fs_period, 400);

    // Frame 3: bypassed frame visible immediately, whole frame blanked.
    tot_sh = 0;
    tot_st = 0;
    for (int r = 0; r < 8; r++)
      run_row(3, r, yw[r], 1'b1, tbl[r].exp_oh, 0, r == 0, -1, '0);
    check("frame period f3", fs_period, 400);
    check("blank frame shcp total", tot_sh, 64);
    check("blank frame stcp total", tot_st, 8);

    // Frame 4: reset asserted in the middle of row 2 HOLD.
    run_row(4, 0, yw[0], 1'b0, 8'h01, 16, 1'b1, -1, '0);
    run_row(4, 1, yw[1], 1'b0, 8'h02, 16, 1'b0, -1, '0);
    for (int k = 0; k < 40; k++) step();
    check("mid-hold rows_out", rows_out, 8'h04);
    check("mid-hold oe", oe, 0);
    reset = 1'b1;
    #1;
    check_reset_values("mid-hold reset");
    $display("reset asserted mid-HOLD at cycle %0d", cyc);
    repeat (3) step();
    last_fs = -1;
    bring_up(1'b0, '0);
    run_row(5, 0, 8'h00, 1'b0, 8'h01, 16, 1'b1, -1, '0);
    run_row(5, 1, 8'h00, 1'b0, 8'h02, 16, 1'b0, -1, '0);

`ifdef MATRIX_SCAN_BRIGHTNESS_EN
    brightness = 4'd3;
    run_row(6, 2, 8'h00, 1'b0, 8'h04, 4, 1'b0, -1, '0);
    brightness = 4'd15;
    run_row(6, 3, 8'h00, 1'b0, 8'h08, 16, 1'b0, -1, '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/matrix_scan_driver.md
# matrix_scan_driver

Parametrised LED-matrix scan driver for the board-level display path, successor to the fixed 8×8 converter. Takes a flattened ROWS×COLS pixel frame from game logic and double-buffers it for tear-free updates. Per row, it serialises column data into an external 74HC595-style shift register, latches it, and then drives the one-hot row line for a fixed hold time. Sits between the game core and the top-level pins (rowsOut, shcp, stcp, mr, oe, ds).

## Interface
Parameters:
- ROWS, 8, matrix rows (2..16)
- COLS, 8, matrix columns / shift-register bits (1..32)
- CLK_DIV, 4, clk cycles per shcp/stcp half-period (≥1)
- ROW_HOLD, 1024, clk cycles each row is lit (≥16)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame  in  ROWS*COLS  pixel data; bit r*COLS+c = row r, column c; 1 = lit
- frame_valid  in  1  single-cycle strobe; captures frame into shadow buffer
- blank  in  1  forces display dark; scanning continues
- rows_out  out  ROWS  one-hot row drive, active-high
- shcp  out  1  shift clock
- stcp  out  1  storage/latch clock
- mr  out  1  shift-register clear, active-low
- oe  out  1  output enable, active-low
- ds  out  1  serial data
- row_idx  out  $clog2(ROWS)  row currently shifting or lit
- frame_start  out  1  one-cycle pulse when the active buffer reloads

## Operation
- Buffers: a shadow register loads on frame_valid in any cycle. The active register copies shadow on entry to row 0 SHIFT. If frame_valid coincides with that copy, the new frame is copied (bypass). frame_start pulses that same cycle.
- FSM: CLEAR → SHIFT → LATCH → HOLD → SHIFT (next row) …
- CLEAR: mr=0 for CLK_DIV cycles, then mr=1, row_idx=0, go to SHIFT. Entered only from reset.
- SHIFT: shifts COLS bits, column COLS-1 first, column 0 last. Per bit: ds valid with shcp=0 for CLK_DIV cycles, then shcp=1 for CLK_DIV cycles. ds is stable across the shcp rising edge. oe=1, rows_out=0 throughout.
- LATCH: stcp=1 for CLK_DIV cycles, shcp=0, oe=1, rows_out=0.
- HOLD: for ROW_HOLD cycles, rows_out has only bit row_idx set and oe=0, unless blank=1, in which case rows_out=0 and oe=1. On exit, row_idx increments and wraps ROWS-1 → 0. The wrap triggers the buffer copy.
- blank is sampled every HOLD cycle and takes effect on the next clock edge. It does not affect SHIFT/LATCH timing.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Timing
- Reset values: rows_out=0, shcp=0, stcp=0, mr=0, oe=1, ds=0, row_idx=0, frame_start=0. Shadow and active buffers are 0. State is CLEAR.
- Asserting reset mid-operation returns immediately to these values. After release, CLEAR runs again.
- Row period P = 2*COLS*CLK_DIV + CLK_DIV + ROW_HOLD cycles. Frame period = ROWS*P.
- First frame_start occurs CLK_DIV+1 cycles after reset deasserts.
- Latency from frame_valid to display: the frame becomes visible at the start of the next frame, at most ROWS*P + 1 cycles later. Multiple frame_valid strobes within one frame: the last one wins.
- Exactly COLS shcp rising edges and one stcp rising edge occur per row.

## Configuration
- MATRIX_SCAN_BRIGHTNESS_EN defined: adds input `brightness` [3:0]. In HOLD, oe=0 (and rows_out is driven) only for the first ((brightness+1)*ROW_HOLD)/16 cycles. For the rest of HOLD, oe=1 and rows_out=0. brightness is sampled at HOLD entry. 15 gives full duty.
- Not defined: no brightness port; oe=0 for the entire HOLD.

## Test plan
Parameters for these tests unless stated: ROWS=8, COLS=8, CLK_DIV=2, ROW_HOLD=16 (P=50).
- Reset/CLEAR: assert reset mid-HOLD, release it → all outputs take their reset values immediately; mr=0 for 2 cycles, then 1; frame_start pulses at cycle 3.
- Serialisation: frame with row 0 = 8'b1010_0011 → 8 shcp rising edges with ds sequence 1,0,1,0,0,0,1,1; one stcp pulse 2 cycles wide; then rows_out=8'b0000_0001 with oe=0 for 16 cycles.
- Scan order/wrap: run 8 rows → rows_out is one-hot 0x01, 0x02 … 0x80 in successive HOLDs, spaced 50 cycles apart; row_idx wraps 7→0; frame_start repeats every 400 cycles.
- Double buffer: strobe frame_valid with all-ones during row 3 → rows 3–7 still show the old data; the new data appears from row 0 of the next frame. A strobe in the same cycle as the wrap is shown immediately.
- Blank: hold blank=1 across a full frame → oe=1 and rows_out=0 the entire time, while shcp/stcp edge counts are unchanged (64 and 8).
- Brightness (macro defined): brightness=3 → oe=0 for exactly 4 of the 16 HOLD cycles; brightness=15 → all 16.
